// File: rtl/gated_loop_pkg.sv
// Shared types and default parameters for the gated loop counter family.
// The FSM encoding is fixed at 2 bits so every file agrees on the state layout.
package gated_loop_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DONE  = 2'd2
    } glc_state_t;

    localparam int GLC_W       = 11;
    localparam int GLC_I_INIT  = 1;
    localparam int GLC_I_LIMIT = 250;

endpackage

// File: rtl/gated_accum_ch.sv
// One gated accumulator channel: counts each advancing step taken while the
// master index is at or below this channel's threshold.
module gated_accum_ch
    import gated_loop_pkg::*;
#(
    parameter int           W      = GLC_W,
    parameter int           I_INIT = GLC_I_INIT,
    parameter logic [W-1:0] GATE_K = W'(150)
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         step,
    input  logic [W-1:0] i,
    output logic [W-1:0] sn,
    output logic         inv_ok
);

    // Count reached once the index has passed the gate: one per index value I_INIT..GATE_K.
    localparam logic [W-1:0] SN_FINAL = W'(int'(GATE_K) - I_INIT + 1);

    logic [W-1:0] sn_reg;
    logic         in_gate;

    assign in_gate = (i <= GATE_K);

    always_ff @(posedge clk) begin
        if (clr) begin
            sn_reg <= '0;
        end else if (step && in_gate) begin
            sn_reg <= sn_reg + 1'b1;
        end
    end

    assign sn     = sn_reg;
    assign inv_ok = in_gate || (sn_reg == SN_FINAL);

endmodule

// File: rtl/gated_loop_counter.sv
// Master loop index with stall/restart control and NCH gated accumulators.
// The index freezes at I_LIMIT+1, which also drives the FSM into DONE.
module gated_loop_counter
    import gated_loop_pkg::*;
#(
    parameter int                 W       = GLC_W,
    parameter int                 NCH     = 2,
    parameter int                 I_INIT  = GLC_I_INIT,
    parameter int                 I_LIMIT = GLC_I_LIMIT,
    parameter logic [NCH*W-1:0]   GATE    = {W'(200), W'(150)}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             selector,
    input  logic             restart,
    output logic [W-1:0]     i,
    output logic [NCH*W-1:0] sn,
    output logic             done,
    output logic             stalled,
    output logic [NCH-1:0]   inv_ok,
    output logic             inv_err
);

    localparam logic [W-1:0] INIT_W  = W'(I_INIT);
    localparam logic [W-1:0] LIMIT_W = W'(I_LIMIT);

    if (I_LIMIT + 1 >= 2**W) begin : g_chk_width
        $error("gated_loop_counter: I_LIMIT+1 does not fit in W bits");
    end
    if (I_INIT > I_LIMIT) begin : g_chk_init
        $error("gated_loop_counter: I_INIT exceeds I_LIMIT");
    end

    glc_state_t   state_reg, state_next;
    logic [W-1:0] i_reg, i_next;
    logic         inv_err_reg;
    logic         clr;
    logic         adv;
    logic         step;

    assign clr  = rst || restart;
    assign adv  = selector && (state_reg != DONE);
    assign step = adv && (i_reg <= LIMIT_W);

    always_comb begin
        i_next     = i_reg;
        state_next = state_reg;
        if (step) begin
            i_next = i_reg + 1'b1;
        end
        if (state_reg == DONE) begin
            state_next = DONE;
        end else if (i_next > LIMIT_W) begin
            state_next = DONE;
        end else if (!selector) begin
            state_next = STALL;
        end else begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            i_reg       <= INIT_W;
            state_reg   <= RUN;
            inv_err_reg <= 1'b0;
        end else begin
            i_reg       <= i_next;
            state_reg   <= state_next;
            inv_err_reg <= inv_err_reg | ~(&inv_ok);
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        if ((int'(GATE[gi*W +: W]) < I_INIT) || (int'(GATE[gi*W +: W]) > I_LIMIT)) begin : g_chk_gate
            $error("gated_loop_counter: GATE slice outside [I_INIT, I_LIMIT]");
        end

        gated_accum_ch #(
            .W      (W),
            .I_INIT (I_INIT),
            .GATE_K (GATE[gi*W +: W])
        ) u_ch (
            .clk    (clk),
            .clr    (clr),
            .step   (step),
            .i      (i_reg),
            .sn     (sn[gi*W +: W]),
            .inv_ok (inv_ok[gi])
        );
    end

    assign i       = i_reg;
    assign done    = (state_reg == DONE);
    assign stalled = (state_reg == STALL);
    assign inv_err = inv_err_reg;

endmodule

// File: tb/tb_gated_loop_counter.sv
// Checks two configurations (default and W=8/NCH=4) side by side against a
// counting reference model under directed and random selector/restart stimulus.
module tb_gated_loop_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        selector = 1'b0;
    logic        restart = 1'b0;

    logic [10:0] i_a;
    logic [21:0] sn_a;
    logic        done_a, stalled_a, inv_err_a;
    logic [1:0]  inv_ok_a;

    logic [7:0]  i_b;
    logic [31:0] sn_b;
    logic        done_b, stalled_b, inv_err_b;
    logic [3:0]  inv_ok_b;

    int total = 0;
    int bad   = 0;

    // Reference model state, one slot per DUT instance.
    int m_i    [2];
    int m_sn   [2][4];
    bit m_done [2];
    bit m_stall[2];
    int lim    [2]    = '{250, 200};
    int nch    [2]    = '{2, 4};
    int wd     [2]    = '{11, 8};
    int gt     [2][4] = '{'{150, 200, 0, 0}, '{1, 50, 100, 200}};

    always #5 clk = ~clk;

    gated_loop_counter u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .selector (selector),
        .restart  (restart),
        .i        (i_a),
        .sn       (sn_a),
        .done     (done_a),
        .stalled  (stalled_a),
        .inv_ok   (inv_ok_a),
        .inv_err  (inv_err_a)
    );

    gated_loop_counter #(
        .W       (8),
        .NCH     (4),
        .I_INIT  (1),
        .I_LIMIT (200),
        .GATE    ({8'd200, 8'd100, 8'd50, 8'd1})
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .selector (selector),
        .restart  (restart),
        .i        (i_b),
        .sn       (sn_b),
        .done     (done_b),
        .stalled  (stalled_b),
        .inv_ok   (inv_ok_b),
        .inv_err  (inv_err_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        for (int x = 0; x < 2; x++) begin
            if (rst || restart) begin
                m_i[x]     = 1;
                m_done[x]  = 1'b0;
                m_stall[x] = 1'b0;
                for (int k = 0; k < 4; k++) m_sn[x][k] = 0;
            end else if (!m_done[x]) begin
                if (selector && m_i[x] <= lim[x]) begin
                    for (int k = 0; k < nch[x]; k++)
                        if (m_i[x] <= gt[x][k]) m_sn[x][k]++;
                    m_i[x]++;
                end
                m_done[x]  = (m_i[x] > lim[x]);
                m_stall[x] = !m_done[x] && !selector;
            end
        end
    endtask

    function automatic logic [63:0] exp_sn(input int x);
        logic [63:0] e = '0;
        for (int k = 0; k < nch[x]; k++)
            e = e | (64'(m_sn[x][k]) << (k * wd[x]));
        return e;
    endfunction

    task automatic compare_all();
        check("a_i", 64'(i_a), 64'(m_i[0]));
        check("a_sn", 64'(sn_a), exp_sn(0));
        check("a_done", 64'(done_a), 64'(m_done[0]));
        check("a_stalled", 64'(stalled_a), 64'(m_stall[0]));
        check("a_inv_ok", 64'(inv_ok_a), 64'(2'b11));
        check("a_inv_err", 64'(inv_err_a), 64'(0));
        check("a_i_bound", 64'(i_a <= 11'd251), 64'(1));
        check("a_sn_bound", 64'(sn_a[10:0] <= 11'd150 && sn_a[21:11] <= 11'd200), 64'(1));
        check("b_i", 64'(i_b), 64'(m_i[1]));
        check("b_sn", 64'(sn_b), exp_sn(1));
        check("b_done", 64'(done_b), 64'(m_done[1]));
        check("b_stalled", 64'(stalled_b), 64'(m_stall[1]));
        check("b_inv_ok", 64'(inv_ok_b), 64'(4'hf));
        check("b_inv_err", 64'(inv_err_b), 64'(0));
        check("b_i_bound", 64'(i_b <= 8'd201), 64'(1));
    endtask

    // Inputs change only at the falling edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        restart  = 1'b0;
        selector = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_i"}, 64'(i_a), 64'(1));
        check({tag, "_sn"}, 64'(sn_a), 64'(0));
        check({tag, "_done"}, 64'(done_a), 64'(0));
        check({tag, "_stalled"}, 64'(stalled_a), 64'(0));
        check({tag, "_inv_err"}, 64'(inv_err_a), 64'(0));
    endtask

    initial begin
        @(negedge clk);

        // Scenario 1: free-running advance
        do_reset(2);
        check_cleared("rst");
        selector = 1'b1;
        repeat (150) tick();
        check("s1_150_i", 64'(i_a), 64'(151));
        check("s1_150_sn", 64'(sn_a), 64'({11'd150, 11'd150}));
        check("s1_150_done", 64'(done_a), 64'(0));
        repeat (100) tick();
        check("s1_250_i", 64'(i_a), 64'(251));
        check("s1_250_sn", 64'(sn_a), 64'({11'd200, 11'd150}));
        check("s1_250_done", 64'(done_a), 64'(1));
        check("s1_b_i", 64'(i_b), 64'(201));
        check("s1_b_sn", 64'(sn_b), 64'({8'd200, 8'd100, 8'd50, 8'd1}));
        check("s1_b_done", 64'(done_b), 64'(1));
        $display("scenario 1 complete: i=%0d sn1=%0d sn0=%0d", i_a, sn_a[21:11], sn_a[10:0]);

        // Scenario 2: ten-cycle stall window
        do_reset(2);
        for (int n = 1; n <= 260; n++) begin
            selector = !(n >= 11 && n <= 20);
            tick();
            if (n >= 11 && n <= 20) begin
                check("s2_stalled", 64'(stalled_a), 64'(1));
                check("s2_frozen_i", 64'(i_a), 64'(11));
            end
            if (n == 259) check("s2_done_early", 64'(done_a), 64'(0));
        end
        check("s2_done", 64'(done_a), 64'(1));
        check("s2_i", 64'(i_a), 64'(251));
        check("s2_sn", 64'(sn_a), 64'({11'd200, 11'd150}));
        $display("scenario 2 complete: i=%0d done=%0b", i_a, done_a);

        // Scenario 3: DONE is absorbing regardless of selector
        for (int n = 0; n < 20; n++) begin
            selector = n[0];
            tick();
            check("s3_i", 64'(i_a), 64'(251));
            check("s3_sn", 64'(sn_a), 64'({11'd200, 11'd150}));
            check("s3_done", 64'(done_a), 64'(1));
        end
        $display("scenario 3 complete: done=%0b", done_a);

        // Scenario 4: restart mid-run, then rst+restart together
        do_reset(1);
        selector = 1'b1;
        repeat (99) tick();
        check("s4_i100", 64'(i_a), 64'(100));
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_cleared("s4_restart");
        repeat (99) tick();
        rst = 1'b1;
        restart = 1'b1;
        tick();
        rst = 1'b0;
        restart = 1'b0;
        check_cleared("s4_both");
        repeat (250) tick();
        check("s4_done", 64'(done_a), 64'(1));
        check("s4_sn", 64'(sn_a), 64'({11'd200, 11'd150}));
        $display("scenario 4 complete: i=%0d done=%0b", i_a, done_a);

        // Scenario 6: random selector / restart / reset
        for (int n = 0; n < 10000; n++) begin
            rst      = ($urandom_range(0, 1999) == 0);
            restart  = ($urandom_range(0, 399) == 0);
            selector = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        restart = 1'b0;
        $display("scenario 6 complete: i=%0d done=%0b", i_a, done_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
